// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit path: framer FSM states and baud timing constants.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } tx_state_e;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned BPS_DIV  = 5208;
  localparam int unsigned BPS_HALF = 2603;

  function automatic logic parity_bit(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit framer: one byte per valid/ready handshake, sent LSB-first as
// start/data/optional parity/stop bits, paced by the BPS_CLK tick it enables via Count_Sig.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 sclk,
  input  logic                 RSTn,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 BPS_CLK,
  output logic                 Count_Sig,
  output logic                 TX_Pin_Out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       HAS_PAR   = (PARITY_EN != 0);
  localparam logic       ODD_PAR   = (PARITY_ODD != 0);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [2:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 count_q;
  logic                 done_q;

  assign tx_ready   = (state_q == ST_IDLE);
  assign tx_busy    = (state_q != ST_IDLE);
  assign Count_Sig  = count_q;
  assign TX_Pin_Out = tx_q;
  assign tx_done    = done_q;

  always_ff @(posedge sclk or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      count_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // BPS_CLK is deliberately not examined here: idle and accept-cycle ticks are dropped.
        ST_IDLE: begin
          if (tx_valid) begin
            shreg_q <= tx_data;
            par_q   <= 1'b0;
            count_q <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (BPS_CLK) begin
            tx_q      <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (BPS_CLK) begin
            tx_q      <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            par_q     <= par_q ^ shreg_q[0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              stop_cnt_q <= 1'b0;
              state_q    <= HAS_PAR ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (BPS_CLK) begin
            tx_q    <= parity_bit(par_q, ODD_PAR);
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (BPS_CLK) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= stop_cnt_q + 1'b1;
            if (stop_cnt_q == LAST_STOP) state_q <= ST_DONE;
          end
        end
        // Extra tick so the final stop bit is held a full period before Count_Sig drops.
        ST_DONE: begin
          if (BPS_CLK) begin
            count_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
